// File: rtl/maxpool_stream_20_2.sv
// rtl/maxpool_stream_20_2.sv - streaming 1-D max-pool, non-overlapping windows of WIN words
module maxpool_stream_20_2 #(
  parameter int T    = 20,
  parameter int N_IN = 13,
  parameter int WIN  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data_in_y,
  input  logic         s_valid_y,
  output logic         s_ready_y,
  output logic [T-1:0] m_data_out_z,
  output logic         m_valid_z,
  input  logic         m_ready_z
);

  localparam int N_OUT = N_IN / WIN;
  localparam int LIM   = N_OUT * WIN;
  localparam int CW    = $clog2(N_IN + 1);
  localparam int WCW   = $clog2(WIN + 1);

  localparam logic [CW-1:0]  IN_LAST  = CW'(N_IN - 1);
  localparam logic [CW-1:0]  IN_LIM   = CW'(LIM);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WIN - 1);

  logic [CW-1:0]  in_cnt_q, in_cnt_d;
  logic [WCW-1:0] win_cnt_q, win_cnt_d;
  logic [T-1:0]   run_max_q, run_max_d;
  logic [T-1:0]   data_q, data_d;
  logic           valid_q, valid_d;

  logic           acc;
  logic           xfer;
  logic           discard;
  logic           take_new;
  logic [T-1:0]   cand;

  // The single output register may be refilled in the same cycle it drains.
  assign s_ready_y    = ~valid_q | m_ready_z;
  assign acc          = s_valid_y & s_ready_y;
  assign xfer         = valid_q & m_ready_z;
  assign m_data_out_z = data_q;
  assign m_valid_z    = valid_q;

  // Tail words beyond the last full window are accepted but never pooled.
  assign discard = (in_cnt_q >= IN_LIM);

  // First word of a window overwrites run_max so a stale value is never compared.
  assign take_new = (win_cnt_q == '0) || ($signed(s_data_in_y) > $signed(run_max_q));
  assign cand     = take_new ? s_data_in_y : run_max_q;

  // Next-state: counters advance on accept, window completion loads the output register.
  always_comb begin
    in_cnt_d  = in_cnt_q;
    win_cnt_d = win_cnt_q;
    run_max_d = run_max_q;
    data_d    = data_q;
    valid_d   = valid_q;
    if (xfer) begin
      valid_d = 1'b0;
    end
    if (acc) begin
      in_cnt_d = (in_cnt_q == IN_LAST) ? '0 : in_cnt_q + CW'(1);
      if (!discard) begin
        if (win_cnt_q == WIN_LAST) begin
          data_d    = cand;
          valid_d   = 1'b1;
          win_cnt_d = '0;
        end else begin
          run_max_d = cand;
          win_cnt_d = win_cnt_q + WCW'(1);
        end
      end
      // Vector boundary always realigns the window so vectors never share a window.
      if (in_cnt_q == IN_LAST) begin
        win_cnt_d = '0;
      end
    end
  end

  // State register with synchronous reset that drops any partial window and pending output.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q  <= '0;
      win_cnt_q <= '0;
      run_max_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      win_cnt_q <= win_cnt_d;
      run_max_q <= run_max_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_maxpool_stream_20_2.sv
// tb/tb_maxpool_stream_20_2.sv - self-checking bench for maxpool_stream_20_2 (WIN=1,2,3)
module tb_maxpool_stream_20_2;

  localparam int T    = 20;
  localparam int N_IN = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [T-1:0] din  [3];
  logic         vin  [3];
  logic         sready [3];
  logic [T-1:0] dout [3];
  logic         vout [3];
  logic         rin  [3];

  maxpool_stream_20_2 #(.T(T), .N_IN(N_IN), .WIN(1)) u_w1 (
    .clk(clk), .reset(reset), .s_data_in_y(din[0]), .s_valid_y(vin[0]), .s_ready_y(sready[0]),
    .m_data_out_z(dout[0]), .m_valid_z(vout[0]), .m_ready_z(rin[0]));
  maxpool_stream_20_2 #(.T(T), .N_IN(N_IN), .WIN(2)) u_w2 (
    .clk(clk), .reset(reset), .s_data_in_y(din[1]), .s_valid_y(vin[1]), .s_ready_y(sready[1]),
    .m_data_out_z(dout[1]), .m_valid_z(vout[1]), .m_ready_z(rin[1]));
  maxpool_stream_20_2 #(.T(T), .N_IN(N_IN), .WIN(3)) u_w3 (
    .clk(clk), .reset(reset), .s_data_in_y(din[2]), .s_valid_y(vin[2]), .s_ready_y(sready[2]),
    .m_data_out_z(dout[2]), .m_valid_z(vout[2]), .m_ready_z(rin[2]));

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: words of each vector grouped into windows, max of each full window queued.
  int ef   [3][64];
  int eh   [3];
  int et   [3];
  int wb   [3][3];
  int wn   [3];
  int pos  [3];
  logic acc_flag [3];
  int got [$];
  int words [$];

  typedef struct {
    int a;
    int b;
    int exp_max;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      eh[k] = 0; et[k] = 0; wn[k] = 0; pos[k] = 0;
    end
  endtask

  task automatic model_accept(input int k, input int d);
    int w;
    int m;
    w = k + 1;
    if (pos[k] < (N_IN / w) * w) begin
      wb[k][wn[k]] = d;
      wn[k]++;
      if (wn[k] == w) begin
        m = wb[k][0];
        for (int i = 1; i < w; i++) if (wb[k][i] > m) m = wb[k][i];
        ef[k][et[k] % 64] = m;
        et[k]++;
        wn[k] = 0;
      end
    end
    pos[k] = (pos[k] + 1) % N_IN;
  endtask

  // Inputs are set just after a negedge; evaluate handshakes, then advance one clock.
  task automatic tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      acc_flag[k] = 1'b0;
      if (!reset) begin
        if (vout[k] && rin[k]) begin
          check($sformatf("pending_w%0d", k + 1), int'(eh[k] < et[k]), 1);
          if (eh[k] < et[k]) begin
            check($sformatf("model_w%0d", k + 1), int'($signed(dout[k])), ef[k][eh[k] % 64]);
            eh[k]++;
          end
          if (k == 1) got.push_back(int'($signed(dout[1])));
        end
        if (vin[k] && sready[k]) begin
          acc_flag[k] = 1'b1;
          model_accept(k, int'($signed(din[k])));
        end
      end
    end
    if (reset) model_reset();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed();
    int i;
    int budget;
    i = 0;
    budget = 0;
    while (i < words.size() && budget < 400) begin
      din[1] = T'(words[i]);
      vin[1] = 1'b1;
      tick();
      if (acc_flag[1]) i++;
      budget++;
    end
    vin[1] = 1'b0;
    check("feed_done", i, words.size());
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 3; k++) vin[k] = 1'b0;
    repeat (n) tick();
  endtask

  task automatic fill_words(input int first, input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(first + i);
  endtask

  initial begin
    tbl[0] = '{-5, 3, 3};
    tbl[1] = '{-7, -2, -2};
    tbl[2] = '{-2, -2, -2};
    tbl[3] = '{3, -5, 3};
    tbl[4] = '{524287, -524288, 524287};
    tbl[5] = '{0, -1, 0};

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k] = '0; vin[k] = 1'b0; rin[k] = 1'b1; acc_flag[k] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", int'(vout[1]), 0);
    check("rst_data", int'(dout[1]), 0);
    check("rst_ready", int'(sready[1]), 1);

    // Stream 0..12: six pooled outputs, last word dropped
    got.delete();
    fill_words(0, 13);
    feed();
    drain(3);
    check("basic_count", got.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("basic_%0d", i), got[i], 2 * i + 1);

    // Signed window table, one full vector plus a dropped tail word
    got.delete();
    words.delete();
    for (int i = 0; i < 6; i++) begin
      words.push_back(tbl[i].a);
      words.push_back(tbl[i].b);
    end
    words.push_back(77);
    feed();
    drain(3);
    check("signed_count", got.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("signed_%0d", i), got[i], tbl[i].exp_max);

    // Backpressure: first output held for 5 cycles, then the rest flows
    got.delete();
    rin[1] = 1'b0;
    fill_words(0, 2);
    feed();
    check("bp_valid_first", int'(vout[1]), 1);
    din[1] = T'(2);
    vin[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_hold_data_%0d", c), int'(dout[1]), 1);
      check($sformatf("bp_hold_valid_%0d", c), int'(vout[1]), 1);
      check($sformatf("bp_sready_%0d", c), int'(sready[1]), 0);
    end
    rin[1] = 1'b1;
    fill_words(2, 11);
    feed();
    drain(3);
    check("bp_count", got.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("bp_%0d", i), got[i], 2 * i + 1);

    // Two vectors back to back
    got.delete();
    fill_words(0, 26);
    feed();
    drain(3);
    check("b2b_count", got.size(), 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("b2b_%0d", i), got[i], (i < 6) ? (2 * i + 1) : (14 + 2 * (i - 6)));

    // Reset with an output pending mid-vector
    got.delete();
    fill_words(0, 4);
    feed();
    rin[1] = 1'b0;
    check("mid_valid_before", int'(vout[1]), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_valid_after", int'(vout[1]), 0);
    check("mid_escaped", got.size(), 1);
    got.delete();
    rin[1] = 1'b1;
    fill_words(100, 13);
    feed();
    drain(3);
    check("fresh_count", got.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("fresh_%0d", i), got[i], 101 + 2 * i);

    // Random gating on all three window sizes against the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        vin[k] = ($urandom_range(0, 3) != 0);
        rin[k] = ($urandom_range(0, 4) > 1);
        din[k] = T'($urandom);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) rin[k] = 1'b1;
    drain(10);
    for (int k = 0; k < 3; k++) check($sformatf("drain_w%0d", k + 1), et[k] - eh[k], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
